// File: rtl/demux1_2_stream.sv
// Registered 1-to-2 stream demultiplexer with an independent 2-entry FIFO per output.
// Optional per-channel pop counters are enabled by defining DEMUX_CNT_EN.
module demux1_2_stream #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data
`ifdef DEMUX_CNT_EN
  ,
  output logic [15:0]      out0_count,
  output logic [15:0]      out1_count
`endif
);

  localparam int unsigned NCH      = 2;
  localparam int unsigned DEPTH    = 2;
  localparam logic [1:0]  OCC_FULL = 2'd2;
  localparam logic [1:0]  OCC_NONE = 2'd0;

  logic [1:0]       occ [NCH];
  logic             wp  [NCH];
  logic             rp  [NCH];
  logic [WIDTH-1:0] mem [NCH][DEPTH];

  logic [NCH-1:0] out_rdy;
  logic [NCH-1:0] push;
  logic [NCH-1:0] pop;

  assign out_rdy = {out1_ready, out0_ready};

  // Ready looks only at registered occupancy, never at the sinks.
  assign in_ready = (in_sel ? occ[1] : occ[0]) != OCC_FULL;

  always_comb begin
    push = '0;
    pop  = '0;
    push[0] = in_valid && in_ready && !in_sel;
    push[1] = in_valid && in_ready &&  in_sel;
    for (int n = 0; n < NCH; n++) begin
      pop[n] = (occ[n] != OCC_NONE) && out_rdy[n];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < NCH; n++) begin
        occ[n]    <= OCC_NONE;
        wp[n]     <= 1'b0;
        rp[n]     <= 1'b0;
        mem[n][0] <= '0;
        mem[n][1] <= '0;
      end
    end else begin
      for (int n = 0; n < NCH; n++) begin
        if (push[n]) begin
          mem[n][wp[n]] <= in_data;
          wp[n]         <= ~wp[n];
        end
        if (pop[n]) begin
          rp[n] <= ~rp[n];
        end
        case ({push[n], pop[n]})
          2'b10:   occ[n] <= occ[n] + 2'd1;
          2'b01:   occ[n] <= occ[n] - 2'd1;
          default: occ[n] <= occ[n];
        endcase
      end
    end
  end

  assign out0_valid = occ[0] != OCC_NONE;
  assign out1_valid = occ[1] != OCC_NONE;
  assign out0_data  = mem[0][rp[0]];
  assign out1_data  = mem[1][rp[1]];

`ifdef DEMUX_CNT_EN
  // Handshake counters wrap naturally at 16 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out0_count <= 16'd0;
      out1_count <= 16'd0;
    end else begin
      if (pop[0]) out0_count <= out0_count + 16'd1;
      if (pop[1]) out1_count <= out1_count + 16'd1;
    end
  end
`endif

endmodule
